// File: rtl/core_id_reg_wb_arb.sv
// ID-stage register file write-port controller: zero-init sequence, EX/LS writeback arbitration.
// Optional same-edge read bypass enabled by defining CORE_ID_REG_WB_BYPASS_EN.
module core_id_reg_wb_arb #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_addr,
  input  logic [31:0] ex_data,
  input  logic        ls_valid,
  output logic        ls_ready,
  input  logic [4:0]  ls_addr,
  input  logic [31:0] ls_data,
  output logic        rf_write_en,
  output logic [4:0]  rf_write_addr,
  output logic [31:0] rf_write_data,
  output logic        init_done,
  input  logic [4:0]  rd0_addr,
  input  logic [4:0]  rd1_addr,
  input  logic [31:0] rf_rd0_data,
  input  logic [31:0] rf_rd1_data,
  output logic [31:0] rd0_data,
  output logic [31:0] rd1_data
);

  // state  | meaning
  // S_INIT | writing zero to x0..x31, no grants
  // S_RUN  | arbitrating EX/LS writebacks, left only by reset
  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic [4:0] init_cnt;
  logic [3:0] starve_cnt;
  logic       run;
  logic       ex_prio;

  assign run      = (state == S_RUN);
  assign ex_prio  = (starve_cnt == LIMIT);
  assign ex_ready = run & ex_valid & (~ls_valid | ex_prio);
  assign ls_ready = run & ls_valid & ~(ex_valid & ex_prio);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_INIT;
      init_cnt      <= '0;
      starve_cnt    <= '0;
      init_done     <= 1'b0;
      rf_write_en   <= 1'b0;
      rf_write_addr <= '0;
      rf_write_data <= '0;
    end else begin
      case (state)
        S_INIT: begin
          rf_write_en   <= 1'b1;
          rf_write_addr <= init_cnt;
          rf_write_data <= '0;
          init_cnt      <= init_cnt + 5'd1;
          if (init_cnt == 5'd31) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        S_RUN: begin
          // x0 writes are accepted but never reach the file
          if (ex_ready) begin
            rf_write_en   <= (ex_addr != 5'd0);
            rf_write_addr <= ex_addr;
            rf_write_data <= ex_data;
          end else if (ls_ready) begin
            rf_write_en   <= (ls_addr != 5'd0);
            rf_write_addr <= ls_addr;
            rf_write_data <= ls_data;
          end else begin
            rf_write_en   <= 1'b0;
          end
          if (ex_valid && !ex_ready) begin
            if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
          end else begin
            starve_cnt <= '0;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

`ifdef CORE_ID_REG_WB_BYPASS_EN
  logic        hit0;
  logic        hit1;
  logic [31:0] byp_data;

  // The file returns pre-write data for a same-edge read; remember the write to patch it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit0     <= 1'b0;
      hit1     <= 1'b0;
      byp_data <= '0;
    end else begin
      hit0     <= rf_write_en && (rd0_addr == rf_write_addr);
      hit1     <= rf_write_en && (rd1_addr == rf_write_addr);
      byp_data <= rf_write_data;
    end
  end

  assign rd0_data = hit0 ? byp_data : rf_rd0_data;
  assign rd1_data = hit1 ? byp_data : rf_rd1_data;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd0_addr, rd1_addr};
  assign rd0_data = rf_rd0_data;
  assign rd1_data = rf_rd1_data;
`endif

endmodule
